dma_controller: RTL

Single-channel DMA controller that moves word blocks between memory-mapped I/O devices (0x8000 region) and data memory without CPU involvement. It sits beside the CPU on the shared data bus, is programmed through a small memory-mapped register file, and is triggered by software or by an I/O device's `request_to_dma` line. It requests the bus from the CPU, waits for a grant, performs read-then-write word transfers, and raises an interrupt on completion.

---
 rtl/dma_controller.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/dma_controller.sv
// Single-channel word DMA: register-programmed, bus-mastering read-then-write copier
// with software or device trigger and a level completion interrupt.
module dma_controller #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_9000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cfg_address,
  input  logic [31:0] cfg_write_data,
  input  logic        cfg_read,
  input  logic        cfg_write,
  output logic [31:0] cfg_read_data,
  input  logic        dev_request,
  output logic        bus_request,
  input  logic        bus_grant,
  output logic [31:0] address,
  output logic [31:0] writeData,
  input  logic [31:0] readData,
  output logic        Read,
  output logic        Write,
  output logic        HAL,
  output logic        irq
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CTRL_W = 5;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_READ, S_WRITE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  src_q, src_d;
  logic [ADDR_W-1:0]  dst_q, dst_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  buf_q, buf_d;
  logic               dev_mode_q, dev_mode_d;
  logic               ie_q, ie_d;
  logic               done_q, done_d;

  logic [ADDR_W-1:0]  offset;
  logic               hit, acc_rd, acc_wr, busy, start_req;
  logic [1:0]         sel;
  logic [CTRL_W-1:0]  ctrl_rd;

  // Offset decode works for any word-aligned base, not just 16-byte aligned ones.
  assign offset = cfg_address - BASE_ADDR;
  assign hit    = (offset[ADDR_W-1:4] == '0) && (offset[1:0] == 2'b00);
  assign sel    = offset[3:2];
  assign acc_rd = hit && cfg_read && !cfg_write;
  assign acc_wr = hit && cfg_write && !cfg_read;
  assign busy   = (state_q != S_IDLE);
  assign ctrl_rd = {busy, done_q, ie_q, dev_mode_q, 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
      buf_q      <= '0;
      dev_mode_q <= 1'b0;
      ie_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      dev_mode_q <= dev_mode_d;
      ie_q       <= ie_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    dev_mode_d = dev_mode_q;
    ie_d       = ie_q;
    done_d     = done_q;
    start_req  = 1'b0;

    // Programming registers are frozen while a transfer is in flight.
    if (acc_wr) begin
      case (sel)
        2'd0: if (!busy) src_d = cfg_write_data;
        2'd1: if (!busy) dst_d = cfg_write_data;
        2'd2: if (!busy) cnt_d = cfg_write_data[CNT_W-1:0];
        default: begin
          dev_mode_d = cfg_write_data[1];
          ie_d       = cfg_write_data[2];
          if (cfg_write_data[3]) done_d = 1'b0;
          start_req  = !busy && cfg_write_data[0];
        end
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if ((start_req || (dev_mode_q && dev_request)) && (cnt_q != '0))
          state_d = S_REQ;
      end
      S_REQ: begin
        if (bus_grant) state_d = S_READ;
      end
      S_READ: begin
        buf_d   = readData;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        src_d = src_q + ADDR_W'(4);
        dst_d = dst_q + ADDR_W'(4);
        cnt_d = cnt_q - CNT_W'(1);
        // Grant is only re-examined on a word boundary.
        if (cnt_q == CNT_W'(1))  state_d = S_DONE;
        else if (bus_grant)      state_d = S_READ;
        else                     state_d = S_REQ;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs decode directly from the state register so reset clears them at once.
  always_comb begin
    bus_request = 1'b0;
    address     = '0;
    writeData   = '0;
    Read        = 1'b0;
    Write       = 1'b0;
    case (state_q)
      S_REQ:   bus_request = 1'b1;
      S_READ: begin
        bus_request = 1'b1;
        address     = src_q;
        Read        = 1'b1;
      end
      S_WRITE: begin
        bus_request = 1'b1;
        address     = dst_q;
        writeData   = buf_q;
        Write       = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    cfg_read_data = '0;
    if (acc_rd) begin
      case (sel)
        2'd0:    cfg_read_data = src_q;
        2'd1:    cfg_read_data = dst_q;
        2'd2:    cfg_read_data = ADDR_W'(cnt_q);
        default: cfg_read_data = ADDR_W'(ctrl_rd);
      endcase
    end
  end

  assign HAL = 1'b0;
  assign irq = done_q & ie_q;

endmodule
